md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Initiator side of the multiply/divide handshake. Sits between the D/E pipeline boundary and the MD unit.
- Registers the MD operation into the E stage and raises start for mult/div.
- Tracks the MD unit's occupancy with a shadow counter and stalls D-stage MD-class instructions (mult/div/mthi/mtlo/mfhi/mflo) until HI/LO are stable.
- Cross-checks the MD unit's busy against its own count and flags any mismatch.

Parameters:
LAT_MUL, 5, busy cycles for mult/multu (must equal MD unit latency)
LAT_DIV, 10, busy cycles for div/divu (must equal MD unit latency)
CNT_W, 4, shadow counter width; must hold LAT_DIV
STALL_W, 16, stall-cycle performance counter width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
d_valid  in  1  D-stage instruction valid
d_md_op  in  4  D-stage MDOp code (package encoding; MD_None for non-MD)
e_flush  in  1  kill the instruction moving D->E at this edge
md_busy  in  1  busy from MD unit
e_md_op  out  4  registered MDOp driven to MD unit
e_start  out  1  start to MD unit
stall_d  out  1  hold D stage (and F) this cycle
err_sync  out  1  sticky shadow/busy mismatch
stall_cnt  out  STALL_W  saturating count of stall_d cycles

Behaviour:
- Reset (reset==0, async): state=IDLE, e_md_op=MD_None, shadow cnt=0, err_sync=0, stall_cnt=0; e_start=0, stall_d=0 follow combinationally. Reset mid-BUSY abandons the count; no stale stall after release.
- is_md(op): op!=MD_None. is_md_start(op): op in {Mult, Multu, Div, Divu}.
- e_start = is_md_start(e_md_op) && state==ISSUE; asserted exactly one cycle per mult/div.
- stall_d = d_valid && is_md(d_md_op) && state!=IDLE. Non-MD instructions never stall.
- E capture at each edge:
  - NONE if e_flush, !d_valid, or stall_d.
  - Otherwise d_md_op.
- FSM:
  - IDLE: if the capture loads a start-class op, go to ISSUE. Otherwise stay in IDLE. Mthi/Mtlo/Mfhi/Mflo pass through e_md_op for one cycle with no state change.
  - ISSUE: e_start=1. At the edge, load cnt with LAT_MUL (Mult/Multu) or LAT_DIV (Div/Divu) and go to BUSY. The capture loads NONE because stall_d is high for MD ops.
  - BUSY: decrement cnt each edge. When cnt==1, go to IDLE (cnt becomes 0). This matches the MD unit's HI/LO write on the same edge.
- Stall latency: an MD op directly behind a mult stalls 1+LAT_MUL = 6 cycles; behind a div, 11 cycles. It enters E the edge after state returns to IDLE.
- Mismatch check, registered, sticky until reset:
  - In BUSY, md_busy must equal 1.
  - In IDLE and ISSUE, md_busy must be 0.
  - Any violation sets err_sync.
- stall_cnt increments on each stall_d cycle and saturates at all-ones (no wrap).
- e_flush has priority over stall and capture. It never cancels an ISSUE/BUSY already underway, because the MD unit has already started.
- Simultaneous d_valid MD op and return to IDLE: stall_d is still 1 that cycle, since it is evaluated on the current state; accepted next cycle.

Decomposition:
- Shared package (parameter include) holds:
  - MDOp codes: MD_None=0, MD_Mult=1, MD_Multu=2, MD_Div=3, MD_Divu=4, MD_Mfhi=5, MD_Mflo=6, MD_Mthi=7, MD_Mtlo=8.
  - FSM state encodings IDLE/ISSUE/BUSY.
  - LAT_MUL/LAT_DIV defaults.
- One natural sub-module: md_shadow_cnt. It takes the load value, decrements, and outputs zero/one flags.

Test Plan:
- Reset low mid-BUSY (cnt=7) then release -> state IDLE, stall_d=0, e_md_op=0 on the first cycle after release.
- D mult followed by D mflo -> e_start high exactly 1 cycle; mflo stall_d high 6 cycles; mflo in e_md_op on the 7th edge; err_sync=0 with a conforming MD model.
- D divu followed by D mthi -> stall 11 cycles; stall_cnt=11; e_start pulses once.
- D mult with e_flush=1 at the capture edge -> e_md_op=MD_None, no e_start, state stays IDLE, no stall of the next op.
- MD model holding md_busy one extra cycle after a mult -> err_sync=1 and stays 1 until reset.
- Force stall_cnt to all-ones-1, then 3 stall cycles -> saturates at all-ones, no wrap; non-MD D instructions during BUSY -> stall_d=0.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared encodings for the multiply/divide issue controller.
// Holds MDOp codes, FSM state encodings, default latencies, op helpers.
package md_issue_ctrl_pkg;

    localparam int LAT_MUL_DEF = 5;
    localparam int LAT_DIV_DEF = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } md_state_e;

    function automatic logic is_md(input logic [3:0] op);
        return op != MD_NONE;
    endfunction

    function automatic logic is_md_mul(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_shadow_cnt.sv
// Shadow occupancy counter mirroring the MD unit's busy window.
// Ports: clk, reset (async low), load/load_val, dec -> cnt, zero, one.
module md_shadow_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             one
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Initiator side of the mult/div handshake: E-stage MDOp register, start
// pulse, D-stage interlock, busy cross-check and stall-cycle counter.
// Ports: clk, reset (async low), d_valid, d_md_op, e_flush, md_busy ->
//        e_md_op, e_start, stall_d, err_sync, stall_cnt.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int LAT_MUL = LAT_MUL_DEF,
    parameter int LAT_DIV = LAT_DIV_DEF,
    parameter int CNT_W   = 4,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [3:0]         d_md_op,
    input  logic               e_flush,
    input  logic               md_busy,
    output logic [3:0]         e_md_op,
    output logic               e_start,
    output logic               stall_d,
    output logic               err_sync,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] LD_MUL = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] LD_DIV = CNT_W'(LAT_DIV);

    md_state_e          state;
    md_state_e          state_nxt;
    logic [3:0]         e_op_q;
    logic [3:0]         cap_op;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_val;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic               cnt_one;
    logic               err_q;
    logic [STALL_W-1:0] stall_q;

    // Interlock looks at the current state only, so an MD op arriving on
    // the cycle the count expires still waits one cycle.
    assign stall_d = d_valid && is_md(d_md_op) && (state != ST_IDLE);

    assign cap_op = (e_flush || !d_valid || stall_d) ? MD_NONE : d_md_op;

    assign cnt_val = is_md_mul(e_op_q) ? LD_MUL : LD_DIV;

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        e_start   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (is_md_start(cap_op)) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                e_start   = is_md_start(e_op_q);
                cnt_load  = 1'b1;
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_dec = 1'b1;
                // zero only reachable through corruption; do not hang
                if (cnt_one || cnt_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            e_op_q <= MD_NONE;
        end else begin
            state  <= state_nxt;
            e_op_q <= cap_op;
        end
    end

    md_shadow_cnt #(
        .CNT_W(CNT_W)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .cnt     (cnt),
        .zero    (cnt_zero),
        .one     (cnt_one)
    );

    // MD unit must be busy exactly while we are in BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (md_busy != (state == ST_BUSY)) begin
            err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (stall_d && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign e_md_op   = e_op_q;
    assign err_sync  = err_q;
    assign stall_cnt = stall_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: a timing-arithmetic reference model
// predicts per-cycle outputs and the stream of ops entering E.
module tb_md_issue_ctrl;

    localparam int LM = 5;
    localparam int LD = 10;
    localparam int SW = 6;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk;
    logic          reset;
    logic          d_valid;
    logic [3:0]    d_md_op;
    logic          e_flush;
    logic          md_busy;
    logic [3:0]    e_md_op;
    logic          e_start;
    logic          stall_d;
    logic          err_sync;
    logic [SW-1:0] stall_cnt;

    md_issue_ctrl #(
        .LAT_MUL(LM),
        .LAT_DIV(LD),
        .CNT_W  (4),
        .STALL_W(SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d_valid  (d_valid),
        .d_md_op  (d_md_op),
        .e_flush  (e_flush),
        .md_busy  (md_busy),
        .e_md_op  (e_md_op),
        .e_start  (e_start),
        .stall_d  (stall_d),
        .err_sync (err_sync),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic stl;
        logic start;
        int   scnt;
        logic err;
    } cyc_exp_t;

    cyc_exp_t   cyc_q[$];
    logic [3:0] op_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int starts_seen = 0;

    // reference model: absolute cycle arithmetic
    int   t        = 0;
    int   issue_at = -1;
    int   free_at  = 0;
    int   total    = 0;
    logic err_m    = 1'b0;
    logic fault_ext = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    function automatic logic starts(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd4;
    endfunction

    task automatic step(input logic rl, input logic dv,
                        input logic [3:0] op, input logic fl,
                        output logic stl);
        logic idle;
        logic in_busy;
        logic mb;
        logic [3:0] cap;
        cyc_exp_t e;
        @(negedge clk);
        if (rl) begin
            issue_at = -1;
            free_at  = 0;
            total    = 0;
            err_m    = 1'b0;
            op_q.delete();
        end
        idle    = (t >= free_at);
        in_busy = (t > issue_at) && (t < free_at);
        mb      = !rl && (in_busy || (fault_ext && t == free_at));
        stl     = dv && (op != 4'd0) && !idle;
        e.stl   = stl;
        e.start = (t == issue_at);
        e.scnt  = (total > SMAX) ? SMAX : total;
        e.err   = err_m;
        cyc_q.push_back(e);
        reset   = !rl;
        d_valid = dv;
        d_md_op = op;
        e_flush = fl;
        md_busy = mb;
        if (!rl) begin
            cap = (fl || !dv || stl) ? 4'd0 : op;
            if (cap != 4'd0) op_q.push_back(cap);
            if (starts(cap)) begin
                issue_at = t + 1;
                free_at  = t + 2 + ((cap <= 4'd2) ? LM : LD);
            end
            if (mb != in_busy) err_m = 1'b1;
            if (stl) total++;
        end
        t++;
    endtask

    // hold an instruction in D until it is accepted; count DUT stalls
    task automatic issue(input logic [3:0] op, input logic fl,
                         output int dn);
        logic stl;
        int   k;
        dn = 0;
        k  = 0;
        do begin
            step(1'b0, 1'b1, op, fl, stl);
            #2;
            if (stall_d) dn++;
            k++;
        end while (stl && k < 40);
        if (stl) begin
            n_checks++;
            n_err++;
            $display("FAIL issue_timeout: op %0d still stalled after %0d cycles, required accept",
                     op, k);
        end
    endtask

    task automatic idle_n(input int n);
        logic stl;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, stl);
    endtask

    task automatic rst_n(input int n);
        logic stl;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 1'b0, stl);
    endtask

    // monitor
    initial begin
        cyc_exp_t e;
        logic [3:0] x;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                chk("stall_d", int'(stall_d), int'(e.stl));
                chk("e_start", int'(e_start), int'(e.start));
                chk("stall_cnt", int'(stall_cnt), e.scnt);
                chk("err_sync", int'(err_sync), int'(e.err));
                if (e_start) starts_seen++;
            end
            if (e_md_op != 4'd0) begin
                if (op_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL e_md_op: got %0d expected none", e_md_op);
                end else begin
                    x = op_q.pop_front();
                    chk("e_md_op", int'(e_md_op), int'(x));
                end
            end
        end
    end

    initial begin
        int dn;
        int s0;
        logic stl;
        logic [3:0] rop;
        reset   = 1'b0;
        d_valid = 1'b0;
        d_md_op = 4'd0;
        e_flush = 1'b0;
        md_busy = 1'b0;

        rst_n(3);
        idle_n(2);

        // mult then mflo
        s0 = starts_seen;
        issue(4'd1, 1'b0, dn);
        issue(4'd6, 1'b0, dn);
        chk("mflo_stall_cycles", dn, 6);
        idle_n(2);
        chk("mult_start_pulses", starts_seen - s0, 1);

        // divu then mthi from clean counters
        rst_n(1);
        s0 = starts_seen;
        issue(4'd4, 1'b0, dn);
        issue(4'd7, 1'b0, dn);
        chk("mthi_stall_cycles", dn, 11);
        idle_n(1);
        #2;
        chk("divu_stall_cnt", int'(stall_cnt), 11);
        chk("divu_start_pulses", starts_seen - s0, 1);

        // flushed mult must leave nothing behind
        s0 = starts_seen;
        step(1'b0, 1'b1, 4'd1, 1'b1, stl);
        issue(4'd6, 1'b0, dn);
        chk("flush_no_stall", dn, 0);
        idle_n(2);
        chk("flush_no_start", starts_seen - s0, 0);

        // reset in the middle of a div
        issue(4'd3, 1'b0, dn);
        idle_n(4);
        rst_n(2);
        issue(4'd5, 1'b0, dn);
        chk("post_reset_no_stall", dn, 0);

        // non-MD traffic during BUSY
        issue(4'd3, 1'b0, dn);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 4'd0, 1'b0, stl);
            #2;
            if (stall_d) dn++;
        end
        chk("nonmd_no_stall", dn, 0);
        idle_n(8);

        // MD unit holds busy one cycle too long
        fault_ext = 1'b1;
        issue(4'd1, 1'b0, dn);
        idle_n(10);
        fault_ext = 1'b0;
        idle_n(5);
        #2;
        chk("err_sticky", int'(err_sync), 1);
        rst_n(1);
        #2;
        chk("err_cleared", int'(err_sync), 0);

        // saturate the stall counter
        for (int i = 0; i < 7; i++) begin
            issue(4'd3, 1'b0, dn);
            issue(4'd8, 1'b0, dn);
        end
        idle_n(1);
        #2;
        chk("stall_cnt_sat", int'(stall_cnt), SMAX);

        // randomized traffic
        rst_n(1);
        for (int i = 0; i < 400; i++) begin
            rop = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'b0, rop, 1'b0, stl);
            end else begin
                issue(rop, ($urandom_range(0, 9) == 0), dn);
            end
        end

        idle_n(14);
        @(negedge clk);
        #4;
        chk("op_q_drain", op_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
